// File: rtl/sol32_alu_unit.sv
// 32-bit ALU with a two-operand unit, a one-operand unit and a condition comparator; optional rotate ops under SOL32_ALU_ROTATE_EN.
// Latency: one cycle from an accepted InValid to registered Result/Flags/CondTrue with OutValid.
// Backpressure: none; an op is accepted every cycle InValid is high.
module sol32_alu_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InValid,
  input  logic        Unit,
  input  logic [3:0]  Op,
  input  logic [3:0]  Cond,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic [31:0] Result,
  output logic [3:0]  Flags,
  output logic        CondTrue,
  output logic        OutValid
);

  // Shared arithmetic datapaths; the carry/borrow bit rides in bit 32.
  logic [32:0] add_w;
  logic [32:0] sub_w;
  logic [32:0] inc_w;
  logic [32:0] dec_w;
  logic [32:0] neg_w;
  logic [4:0]  sh_amt;

  assign add_w  = {1'b0, SrcA} + {1'b0, SrcB};
  assign sub_w  = {1'b0, SrcA} - {1'b0, SrcB};
  assign inc_w  = {1'b0, SrcA} + 33'd1;
  assign dec_w  = {1'b0, SrcA} - 33'd1;
  assign neg_w  = 33'd0 - {1'b0, SrcA};
  assign sh_amt = SrcB[4:0];

`ifdef SOL32_ALU_ROTATE_EN
  // A right shift by 32 yields zero, which covers a rotate amount of 0.
  logic [31:0] rol_w;
  logic [31:0] ror_w;
  logic [5:0]  rot_inv;
  assign rot_inv = 6'd32 - {1'b0, sh_amt};
  assign rol_w   = (SrcA << sh_amt) | (SrcA >> rot_inv);
  assign ror_w   = (SrcA >> sh_amt) | (SrcA << rot_inv);
`endif

  // Bit counters for CLZ/CTZ/POPCNT; an all-zero operand gives 32 for both scans.
  logic [5:0] clz_cnt;
  logic [5:0] ctz_cnt;
  logic [5:0] pop_cnt;

  // Scan once upward for CLZ/POPCNT and once downward so the lowest set bit wins for CTZ.
  always_comb begin
    clz_cnt = 6'd32;
    ctz_cnt = 6'd32;
    pop_cnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      if (SrcA[i]) clz_cnt = 6'(31 - i);
      pop_cnt = pop_cnt + {5'd0, SrcA[i]};
    end
    for (int j = 31; j >= 0; j--) begin
      if (SrcA[j]) ctz_cnt = 6'(j);
    end
  end

  // Operation select; anything not decoded leaves result and C/V at zero, so Z reads 1.
  logic [31:0] res;
  logic        c_flag;
  logic        v_flag;
  logic        n_flag;
  logic        z_flag;

  // Compute the result and carry/overflow of the selected unit and op.
  always_comb begin
    res    = 32'd0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    if (!Unit) begin
      case (Op)
        4'd0: begin
          res    = add_w[31:0];
          c_flag = add_w[32];
          v_flag = (SrcA[31] == SrcB[31]) && (add_w[31] != SrcA[31]);
        end
        4'd1: begin
          res    = sub_w[31:0];
          c_flag = sub_w[32];
          v_flag = (SrcA[31] != SrcB[31]) && (sub_w[31] != SrcA[31]);
        end
        4'd2:  res = SrcA & SrcB;
        4'd3:  res = SrcA | SrcB;
        4'd4:  res = SrcA ^ SrcB;
        4'd5:  res = SrcA << sh_amt;
        4'd6:  res = SrcA >> sh_amt;
        4'd7:  res = $unsigned($signed(SrcA) >>> sh_amt);
        4'd8:  res = {31'd0, $signed(SrcA) < $signed(SrcB)};
        4'd9:  res = {31'd0, SrcA < SrcB};
        4'd10: res = SrcB;
`ifdef SOL32_ALU_ROTATE_EN
        4'd11: res = rol_w;
        4'd12: res = ror_w;
`endif
        default: res = 32'd0;
      endcase
    end else begin
      case (Op)
        4'd0: res = ~SrcA;
        4'd1: begin
          res    = neg_w[31:0];
          c_flag = neg_w[32];
          v_flag = (SrcA == 32'h8000_0000);
        end
        4'd2: begin
          res    = inc_w[31:0];
          c_flag = inc_w[32];
          v_flag = (SrcA == 32'h7FFF_FFFF);
        end
        4'd3: begin
          res    = dec_w[31:0];
          c_flag = dec_w[32];
          v_flag = (SrcA == 32'h8000_0000);
        end
        4'd4:  res = {26'd0, clz_cnt};
        4'd5:  res = {26'd0, ctz_cnt};
        4'd6:  res = {26'd0, pop_cnt};
        4'd7:  res = {{24{SrcA[7]}}, SrcA[7:0]};
        4'd8:  res = {{16{SrcA[15]}}, SrcA[15:0]};
        4'd9:  res = {24'd0, SrcA[7:0]};
        4'd10: res = {16'd0, SrcA[15:0]};
        4'd11: res = {SrcA[7:0], SrcA[15:8], SrcA[23:16], SrcA[31:24]};
        default: res = 32'd0;
      endcase
    end
  end

  assign n_flag = res[31];
  assign z_flag = (res == 32'd0);

  // Condition evaluation; flag-based codes use this cycle's op, not the registered Flags.
  logic cond_w;

  // Decode the comparator condition against the raw operands or current flags.
  always_comb begin
    cond_w = 1'b0;
    case (Cond)
      4'd0:  cond_w = (SrcA == SrcB);
      4'd1:  cond_w = (SrcA != SrcB);
      4'd2:  cond_w = ($signed(SrcA) <  $signed(SrcB));
      4'd3:  cond_w = ($signed(SrcA) >= $signed(SrcB));
      4'd4:  cond_w = (SrcA <  SrcB);
      4'd5:  cond_w = (SrcA >= SrcB);
      4'd6:  cond_w = ($signed(SrcA) >  $signed(SrcB));
      4'd7:  cond_w = ($signed(SrcA) <= $signed(SrcB));
      4'd8:  cond_w = (SrcA >  SrcB);
      4'd9:  cond_w = (SrcA <= SrcB);
      4'd10: cond_w = n_flag;
      4'd11: cond_w = !n_flag;
      4'd12: cond_w = v_flag;
      4'd13: cond_w = !v_flag;
      4'd14: cond_w = 1'b1;
      default: cond_w = 1'b0;
    endcase
  end

  // Output registers: reset clears everything, idle cycles hold data and drop OutValid.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Result   <= 32'd0;
      Flags    <= 4'd0;
      CondTrue <= 1'b0;
      OutValid <= 1'b0;
    end else begin
      OutValid <= InValid;
      if (InValid) begin
        Result   <= res;
        Flags    <= {v_flag, c_flag, n_flag, z_flag};
        CondTrue <= cond_w;
      end
    end
  end

endmodule

// File: tb/tb_sol32_alu_unit.sv
// Directed-vector bench for sol32_alu_unit with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
// Default build exercises the rotate-disabled behaviour unless SOL32_ALU_ROTATE_EN is set.
module tb_sol32_alu_unit;

  logic        Clock;
  logic        Reset;
  logic        InValid;
  logic        Unit;
  logic [3:0]  Op;
  logic [3:0]  Cond;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] Result;
  logic [3:0]  Flags;
  logic        CondTrue;
  logic        OutValid;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  sol32_alu_unit dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .InValid  (InValid),
    .Unit     (Unit),
    .Op       (Op),
    .Cond     (Cond),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .Result   (Result),
    .Flags    (Flags),
    .CondTrue (CondTrue),
    .OutValid (OutValid)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Present one cycle of inputs, then sample after the capturing edge.
  task automatic step(input logic rst, input logic vld, input logic u, input logic [3:0] o,
                      input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clock);
    Reset   = rst;
    InValid = vld;
    Unit    = u;
    Op      = o;
    Cond    = c;
    SrcA    = a;
    SrcB    = b;
    @(posedge Clock);
    #1;
  endtask

  // Issue one valid op and check all four outputs.
  task automatic run_op(input string tag, input logic u, input logic [3:0] o, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [3:0] exp_flg, input logic exp_ct);
    step(1'b0, 1'b1, u, o, c, a, b);
    check({tag, ".res"}, Result, exp_res);
    check({tag, ".flg"}, {28'd0, Flags}, {28'd0, exp_flg});
    check({tag, ".ct"},  {31'd0, CondTrue}, {31'd0, exp_ct});
    check({tag, ".ov"},  {31'd0, OutValid}, 32'd1);
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b0; Unit = 1'b0; Op = 4'd0; Cond = 4'd0; SrcA = '0; SrcB = '0;

    // Reset overrides a valid op presented in the same cycle.
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd14, 32'h1234_5678, 32'h1);
    check("rst.res", Result, 32'd0);
    check("rst.flg", {28'd0, Flags}, 32'd0);
    check("rst.ct",  {31'd0, CondTrue}, 32'd0);
    check("rst.ov",  {31'd0, OutValid}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd14, 32'h1234_5678, 32'h1);
    check("idle.ov",  {31'd0, OutValid}, 32'd0);
    check("idle.res", Result, 32'd0);
    check("idle.ct",  {31'd0, CondTrue}, 32'd0);

    // Flags are {V,C,N,Z}.
    run_op("add_wrap", 1'b0, 4'd0,  4'd0,  32'hFFFF_FFFF, 32'h1,  32'h0,         4'b0101, 1'b0);
    run_op("sub_ovf",  1'b0, 4'd1,  4'd2,  32'h8000_0000, 32'h1,  32'h7FFF_FFFF, 4'b1000, 1'b1);
    run_op("add_v",    1'b0, 4'd0,  4'd12, 32'h7FFF_FFFF, 32'h1,  32'h8000_0000, 4'b1010, 1'b1);
    run_op("sub_brw",  1'b0, 4'd1,  4'd4,  32'h1,         32'h2,  32'hFFFF_FFFF, 4'b0110, 1'b1);
    run_op("and",      1'b0, 4'd2,  4'd1,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 4'b0000, 1'b1);
    run_op("xor_z",    1'b0, 4'd4,  4'd0,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0,  4'b0001, 1'b1);
    run_op("shl",      1'b0, 4'd5,  4'd15, 32'h0000_0003, 32'h1F, 32'h8000_0000, 4'b0010, 1'b0);
    run_op("shr",      1'b0, 4'd6,  4'd14, 32'h8000_0000, 32'h4,  32'h0800_0000, 4'b0000, 1'b1);
    run_op("sar",      1'b0, 4'd7,  4'd10, 32'h8000_0000, 32'h4,  32'hF800_0000, 4'b0010, 1'b1);
    run_op("slt",      1'b0, 4'd8,  4'd11, 32'hFFFF_FFFF, 32'h1,  32'h1,         4'b0000, 1'b1);
    run_op("sltu",     1'b0, 4'd9,  4'd13, 32'hFFFF_FFFF, 32'h1,  32'h0,         4'b0001, 1'b1);
    run_op("movb",     1'b0, 4'd10, 4'd3,  32'h5,         32'hCAFE_0000, 32'hCAFE_0000, 4'b0010, 1'b1);
`ifdef SOL32_ALU_ROTATE_EN
    run_op("rol",      1'b0, 4'd11, 4'd0,  32'h8000_0001, 32'h4,  32'h0000_0018, 4'b0000, 1'b0);
    run_op("ror",      1'b0, 4'd12, 4'd0,  32'h8000_0001, 32'h4,  32'h1800_0000, 4'b0000, 1'b0);
`else
    run_op("rol_off",  1'b0, 4'd11, 4'd0,  32'h8000_0001, 32'h4,  32'h0,         4'b0001, 1'b0);
    run_op("ror_off",  1'b0, 4'd12, 4'd0,  32'h8000_0001, 32'h4,  32'h0,         4'b0001, 1'b0);
`endif
    run_op("undef2",   1'b0, 4'd15, 4'd0,  32'h1,         32'h1,  32'h0,         4'b0001, 1'b1);

    // Comparator on raw operands: -1 vs 1.
    run_op("gtu",      1'b0, 4'd2,  4'd8,  32'hFFFF_FFFF, 32'h1,  32'h1,         4'b0000, 1'b1);
    run_op("gt",       1'b0, 4'd2,  4'd6,  32'hFFFF_FFFF, 32'h1,  32'h1,         4'b0000, 1'b0);
    run_op("le",       1'b0, 4'd2,  4'd7,  32'hFFFF_FFFF, 32'h1,  32'h1,         4'b0000, 1'b1);
    run_op("leu",      1'b0, 4'd2,  4'd9,  32'hFFFF_FFFF, 32'h1,  32'h1,         4'b0000, 1'b0);
    run_op("geu",      1'b0, 4'd2,  4'd5,  32'hFFFF_FFFF, 32'h1,  32'h1,         4'b0000, 1'b1);

    // One-operand unit.
    run_op("clz",      1'b1, 4'd4,  4'd0,  32'h0001_0000, 32'h0,  32'd15,        4'b0000, 1'b0);
    run_op("popcnt",   1'b1, 4'd6,  4'd0,  32'hF0F0_F0F0, 32'h0,  32'd16,        4'b0000, 1'b0);
    run_op("ctz0",     1'b1, 4'd5,  4'd0,  32'h0,         32'h0,  32'd32,        4'b0000, 1'b1);
    run_op("clz0",     1'b1, 4'd4,  4'd0,  32'h0,         32'h0,  32'd32,        4'b0000, 1'b1);
    run_op("ctz",      1'b1, 4'd5,  4'd0,  32'h0000_0100, 32'h0,  32'd8,         4'b0000, 1'b0);
    run_op("not",      1'b1, 4'd0,  4'd0,  32'h0000_FFFF, 32'h0,  32'hFFFF_0000, 4'b0010, 1'b0);
    run_op("neg_min",  1'b1, 4'd1,  4'd12, 32'h8000_0000, 32'h0,  32'h8000_0000, 4'b1110, 1'b1);
    run_op("neg0",     1'b1, 4'd1,  4'd13, 32'h0,         32'h0,  32'h0,         4'b0001, 1'b1);
    run_op("inc_v",    1'b1, 4'd2,  4'd0,  32'h7FFF_FFFF, 32'h0,  32'h8000_0000, 4'b1010, 1'b0);
    run_op("inc_c",    1'b1, 4'd2,  4'd0,  32'hFFFF_FFFF, 32'h0,  32'h0,         4'b0101, 1'b0);
    run_op("dec0",     1'b1, 4'd3,  4'd0,  32'h0,         32'h0,  32'hFFFF_FFFF, 4'b0110, 1'b1);
    run_op("dec_v",    1'b1, 4'd3,  4'd0,  32'h8000_0000, 32'h0,  32'h7FFF_FFFF, 4'b1000, 1'b0);
    run_op("sextb",    1'b1, 4'd7,  4'd0,  32'h1234_5680, 32'h0,  32'hFFFF_FF80, 4'b0010, 1'b0);
    run_op("sexth",    1'b1, 4'd8,  4'd0,  32'h1234_7FFF, 32'h0,  32'h0000_7FFF, 4'b0000, 1'b0);
    run_op("zextb",    1'b1, 4'd9,  4'd0,  32'hFFFF_FF80, 32'h0,  32'h0000_0080, 4'b0000, 1'b0);
    run_op("zexth",    1'b1, 4'd10, 4'd0,  32'hFFFF_8001, 32'h0,  32'h0000_8001, 4'b0000, 1'b0);
    run_op("bswap",    1'b1, 4'd11, 4'd0,  32'h1122_3344, 32'h0,  32'h4433_2211, 4'b0000, 1'b0);
    run_op("undef1",   1'b1, 4'd14, 4'd0,  32'hFFFF_FFFF, 32'h0,  32'h0,         4'b0001, 1'b0);

    // Idle cycle holds data and drops OutValid.
    run_op("pre_hold", 1'b0, 4'd3,  4'd14, 32'h00F0_0000, 32'h0000_000F, 32'h00F0_000F, 4'b0000, 1'b1);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd15, 32'hDEAD_BEEF, 32'h0);
    check("hold.ov",  {31'd0, OutValid}, 32'd0);
    check("hold.res", Result, 32'h00F0_000F);
    check("hold.flg", {28'd0, Flags}, 32'd0);
    check("hold.ct",  {31'd0, CondTrue}, 32'd1);

    // An op in flight when reset hits is discarded, then the next edge accepts immediately.
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd14, 32'h7FFF_FFFF, 32'h1);
    check("rst2.res", Result, 32'd0);
    check("rst2.flg", {28'd0, Flags}, 32'd0);
    check("rst2.ct",  {31'd0, CondTrue}, 32'd0);
    check("rst2.ov",  {31'd0, OutValid}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd14, 32'h7FFF_FFFF, 32'h1);
    check("rst2i.ov",  {31'd0, OutValid}, 32'd0);
    check("rst2i.res", Result, 32'd0);
    run_op("post_rst", 1'b0, 4'd0,  4'd0,  32'h2,         32'h3,  32'h5,         4'b0000, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sol32_alu_unit.md
SOL32_ALU_UNIT -- requirements
Module: sol32_alu_unit

Interface
REQ-001 SHALL have no parameters; datapath fixed at 32 bits.
REQ-002 Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 InValid  input  1  operation presented this cycle.
REQ-005 Unit  input  1  0 = two-operand unit (alu2), 1 = one-operand unit (alu1).
REQ-006 Op  input  4  operation code for selected unit.
REQ-007 Cond  input  4  comparator condition code.
REQ-008 SrcA  input  32  operand A.
REQ-009 SrcB  input  32  operand B (ignored by alu1).
REQ-010 Result  output  32  registered result.
REQ-011 Flags  output  4  registered flags {V,C,N,Z} = bits [3:0] as V=3, C=2, N=1, Z=0.
REQ-012 CondTrue  output  1  registered comparator outcome.
REQ-013 OutValid  output  1  registered; high one cycle after accepted InValid.

Function
REQ-014 Latency SHALL be exactly 1 cycle: InValid=1 at edge k updates Result/Flags/CondTrue and sets OutValid=1 after edge k; no backpressure, one op accepted per cycle.
REQ-015 InValid=0 at an edge SHALL clear OutValid and hold Result/Flags/CondTrue.
REQ-016 alu2 ops: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR logical, 7 SAR, 8 SLT signed (1/0), 9 SLTU (1/0), 10 MOVB (pass B), 11 ROL, 12 ROR; shift/rotate amount = SrcB[4:0].
REQ-017 alu1 ops on SrcA: 0 NOT, 1 NEG (0-A), 2 INC, 3 DEC, 4 CLZ, 5 CTZ, 6 POPCNT, 7 SEXT byte, 8 SEXT half, 9 ZEXT byte, 10 ZEXT half, 11 byte reverse; CLZ/CTZ of 0 = 32.
REQ-018 Undefined op codes SHALL produce Result=0, Flags Z=1, others 0.
REQ-019 Z = (Result==0); N = Result[31] for every op.
REQ-020 C: ADD/INC = carry-out; SUB/DEC/NEG = borrow (1 when unsigned A<subtrahend); all other ops C=0.
REQ-021 V: signed overflow for ADD, SUB, INC, DEC, NEG (NEG V=1 only for A=0x80000000); all other ops V=0.
REQ-022 Arithmetic SHALL wrap modulo 2^32.
REQ-023 Comparator Cond 0-9 SHALL compare SrcA vs SrcB directly, independent of Unit/Op: 0 EQ, 1 NE, 2 LT signed, 3 GE signed, 4 LTU, 5 GEU, 6 GT signed, 7 LE signed, 8 GTU, 9 LEU.
REQ-024 Cond 10 N set, 11 N clear, 12 V set, 13 V clear: use flags of the operation executed in the same cycle (not registered Flags).
REQ-025 Cond 14 SHALL be always 1; Cond 15 always 0.

Reset
REQ-026 Reset=1 at an edge SHALL force Result=0, Flags=0, CondTrue=0, OutValid=0, overriding InValid.
REQ-027 Reset deasserted SHALL allow an op at the very next edge; an op in flight when Reset is asserted SHALL be discarded.

Configuration
REQ-028 Macro SOL32_ALU_ROTATE_EN defined: alu2 ops 11 ROL and 12 ROR implemented per REQ-016.
REQ-029 SOL32_ALU_ROTATE_EN undefined: ops 11, 12 SHALL behave as undefined per REQ-018; no rotate logic synthesized.

Verification
REQ-030 Unit=0, Op=0, A=0xFFFFFFFF, B=1, InValid=1 -> next cycle Result=0, Flags Z=1, C=1, N=0, V=0, OutValid=1.
REQ-031 Unit=0, Op=1, A=0x80000000, B=1, Cond=2 -> Result=0x7FFFFFFF, V=1, C=0, CondTrue=1 (signed -2^31 < 1).
REQ-032 Unit=1, Op=4, A=0x00010000 -> Result=15; Op=6, A=0xF0F0F0F0 -> Result=16; Op=5, A=0 -> Result=32.
REQ-033 Cond=8, A=0xFFFFFFFF, B=1 -> CondTrue=1; Cond=6, same operands -> CondTrue=0.
REQ-034 Unit=0, Op=11, A=0x80000001, B=4 -> Result=0x00000018 with SOL32_ALU_ROTATE_EN; Result=0, Z=1 without.
REQ-035 InValid=1 with Reset=1 -> all outputs 0 next cycle; following cycle InValid=0 -> OutValid=0, outputs held at 0.
